// File: rtl/if_fetch_queue_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package gpcore_fetch_pkg;

    localparam int                    FETCH_XLEN       = 32;
    localparam logic [31:0]           NOP_INSTR        = 32'h0000_0013;
    localparam logic [FETCH_XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [31:0]           instr;
    } fetch_entry_t;

    // Drop the byte offset so every fetch address is word aligned.
    function automatic logic [FETCH_XLEN-1:0] word_align(input logic [FETCH_XLEN-1:0] addr);
        return {addr[FETCH_XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_queue_if.sv
// Fetch-stage bus: scoreboard control, instruction memory and decode handoff.
interface if_fetch_queue_if
    import gpcore_fetch_pkg::*;
#(
    parameter int XLEN = FETCH_XLEN
);
    logic            stall;
    logic            kill;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic            instr_valid;
    logic [31:0]     instr;
    logic [XLEN-1:0] instr_pc;

    modport master (
        input  stall, kill, redirect_pc, imem_rdata,
        output imem_req, imem_addr, instr_valid, instr, instr_pc
    );

    modport slave (
        output stall, kill, redirect_pc, imem_rdata,
        input  imem_req, imem_addr, instr_valid, instr, instr_pc
    );
endinterface

// File: rtl/if_fetch_queue_sync_fifo.sv
// Small synchronous FIFO of fetch entries with single-cycle flush.
module sync_fifo
    import gpcore_fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CNT_W = AW + 1
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  fetch_entry_t wdata_i,
    output fetch_entry_t rdata_o,
    output logic [CNT_W-1:0] count_o,
    output logic         full_o,
    output logic         empty_o
);
    fetch_entry_t     mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Pointer and occupancy next-state; flush wins over push and pop.
    always_comb begin
        do_push  = push_i && !flush_i && !full_o;
        do_pop   = pop_i && !flush_i && !empty_o;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control registers, cleared asynchronously.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful while counted.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction fetch: sequential PC generation, 1-cycle imem, decoupling queue.
module if_fetch_queue
    import gpcore_fetch_pkg::*;
#(
    parameter int              XLEN     = FETCH_XLEN,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input logic              clk,
    input logic              nrst,
    if_fetch_queue_if.master fq
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic             req_q, req_d;
    logic             drop_q, drop_d;
    logic             req, push, pop, head_valid;
    logic [CNT_W-1:0] count;
    logic [CNT_W:0]   occupancy;
    logic             full, empty;
    fetch_entry_t     head, incoming;

    // Request/handshake decode; every in-flight response keeps a slot reserved.
    always_comb begin
        occupancy  = {1'b0, count} + {{CNT_W{1'b0}}, req_q};
        req        = nrst && !fq.kill && (occupancy < (CNT_W+1)'(DEPTH));
        head_valid = !empty && !fq.kill;
        push       = req_q && !drop_q && !fq.kill;
        pop        = head_valid && !fq.stall;
        incoming   = '{pc: pc_q, instr: fq.imem_rdata};
    end

    assign fq.imem_req    = req;
    assign fq.imem_addr   = fetch_pc_q;
    assign fq.instr_valid = head_valid;
    assign fq.instr       = head_valid ? head.instr : NOP_INSTR;
    assign fq.instr_pc    = head_valid ? head.pc : '0;

    // Next PC, request tracking and stale-response drop on kill.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        pc_d       = pc_q;
        req_d      = req;
        drop_d     = 1'b0;
        if (fq.kill) begin
            fetch_pc_d = word_align(fq.redirect_pc);
            drop_d     = req_q;
        end else if (req) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        end
        if (req) pc_d = fetch_pc_q;
    end

    // Control state, cleared asynchronously.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            fetch_pc_q <= RESET_PC;
            req_q      <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_q      <= req_d;
            drop_q     <= drop_d;
        end
    end

    // Address of the outstanding request; qualified by req_q.
    always_ff @(posedge clk) begin
        pc_q <= pc_d;
    end

    sync_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .nrst    (nrst),
        .flush_i (fq.kill),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (incoming),
        .rdata_o (head),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (!nrst) !(push && full))
        else $error("fetch queue overflow");

endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomized bench for if_fetch_queue against a queue-based reference model.
module tb_if_fetch_queue;
    import gpcore_fetch_pkg::*;

    localparam int DEPTH = 4;

    logic clk  = 1'b0;
    logic nrst = 1'b0;

    if_fetch_queue_if #(.XLEN(32)) fq();

    if_fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk  (clk),
        .nrst (nrst),
        .fq   (fq)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h0BAD_F00D;
    endfunction

    // Instruction memory: data for a request appears in the following cycle.
    always @(posedge clk) fq.imem_rdata <= fq.imem_req ? mem_word(fq.imem_addr) : 32'hDEAD_BEEF;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ment_t;

    int          n_assert = 0;
    int          n_fail   = 0;
    ment_t       mq[$];
    logic [31:0] m_fetch;
    bit          m_infl;
    logic [31:0] m_infl_addr;
    bit          m_drop;
    logic [31:0] got_pc[$];
    logic        o_req, o_valid;
    logic [31:0] o_addr, o_pc;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_fetch = 32'h0;
        m_infl  = 1'b0;
        m_drop  = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst_imem_req", fq.imem_req, 0);
        check("rst_instr_valid", fq.instr_valid, 0);
        check("rst_instr", fq.instr, 32'h0000_0013);
        check("rst_instr_pc", fq.instr_pc, 0);
    endtask

    // One cycle: drive at negedge, compare settled outputs, advance the model.
    task automatic step(input bit s, input bit k, input logic [31:0] rp);
        bit          m_req, m_valid;
        logic [31:0] e_instr, e_pc;
        ment_t       e;
        fq.stall = s;
        fq.kill = k;
        fq.redirect_pc = rp;
        #1;
        m_req   = !k && ((mq.size() + int'(m_infl)) < DEPTH);
        m_valid = (mq.size() != 0) && !k;
        e_instr = 32'h0000_0013;
        e_pc    = 32'h0;
        if (m_valid) begin
            e_instr = mq[0].ins;
            e_pc    = mq[0].pc;
        end
        check("imem_req", fq.imem_req, m_req);
        if (m_req) check("imem_addr", fq.imem_addr, m_fetch);
        check("instr_valid", fq.instr_valid, m_valid);
        check("instr", fq.instr, e_instr);
        check("instr_pc", fq.instr_pc, e_pc);
        o_req   = fq.imem_req;
        o_valid = fq.instr_valid;
        o_addr  = fq.imem_addr;
        o_pc    = fq.instr_pc;
        if (fq.instr_valid && !s) got_pc.push_back(fq.instr_pc);
        if (k) begin
            mq.delete();
            m_fetch = {rp[31:2], 2'b00};
            m_drop  = m_infl;
            m_infl  = 1'b0;
        end else begin
            if (m_valid && !s) void'(mq.pop_front());
            if (m_infl && !m_drop) begin
                check("no_overflow", mq.size() < DEPTH, 1);
                e.pc  = m_infl_addr;
                e.ins = mem_word(m_infl_addr);
                mq.push_back(e);
            end
            m_drop = 1'b0;
            if (m_req) begin
                m_infl      = 1'b1;
                m_infl_addr = m_fetch;
                m_fetch     = m_fetch + 32'd4;
            end else begin
                m_infl = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic run_until(input string nm, input int n, input int bound);
        int cnt = 0;
        while (got_pc.size() < n && cnt < bound) begin
            step(1'b0, 1'b0, 32'h0);
            cnt++;
        end
        check({"wait_", nm}, got_pc.size() >= n, 1);
    endtask

    initial begin
        logic [31:0] held;
        fq.stall = 1'b0;
        fq.kill = 1'b0;
        fq.redirect_pc = 32'h0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk);
        nrst = 1'b1;

        // Free-running startup.
        repeat (12) step(1'b0, 1'b0, 32'h0);
        check("startup_count", got_pc.size() >= 3, 1);
        if (got_pc.size() >= 3) begin
            check("startup_pc0", got_pc[0], 32'h0);
            check("startup_pc1", got_pc[1], 32'h4);
            check("startup_pc2", got_pc[2], 32'h8);
        end

        // Long stall fills the queue and holds the head.
        step(1'b1, 1'b0, 32'h0);
        held = o_pc;
        repeat (9) begin
            step(1'b1, 1'b0, 32'h0);
            check("stall_hold", o_pc, held);
        end
        check("stall_full_req", o_req, 0);
        check("stall_valid", o_valid, 1);
        repeat (8) step(1'b0, 1'b0, 32'h0);
        for (int i = 1; i < got_pc.size(); i++) check("seq_pc", got_pc[i], got_pc[i-1] + 32'd4);

        // Single-cycle kill with entries queued and a request in flight.
        repeat (2) step(1'b1, 1'b0, 32'h0);
        got_pc.delete();
        step(1'b0, 1'b1, 32'h100);
        check("kill_valid", o_valid, 0);
        run_until("kill100", 2, 12);
        if (got_pc.size() >= 2) begin
            check("kill_pc0", got_pc[0], 32'h100);
            check("kill_pc1", got_pc[1], 32'h104);
        end

        // Two-cycle kill: last redirect wins.
        got_pc.delete();
        step(1'b0, 1'b1, 32'h200);
        step(1'b0, 1'b1, 32'h300);
        run_until("kill300", 1, 12);
        if (got_pc.size() >= 1) check("kill2_pc0", got_pc[0], 32'h300);

        // Kill together with stall on a full queue.
        repeat (8) step(1'b1, 1'b0, 32'h0);
        check("full_req", o_req, 0);
        got_pc.delete();
        step(1'b1, 1'b1, 32'h400);
        run_until("kill400", 1, 12);
        if (got_pc.size() >= 1) check("killstall_pc0", got_pc[0], 32'h400);

        // Misaligned redirect.
        step(1'b0, 1'b1, 32'h102);
        step(1'b0, 1'b0, 32'h0);
        check("align_req", o_req, 1);
        check("align_addr", o_addr, 32'h100);

        // PC wrap past the top of the address space.
        got_pc.delete();
        step(1'b0, 1'b1, 32'hFFFF_FFF8);
        run_until("wrap", 3, 16);
        if (got_pc.size() >= 3) check("wrap_pc2", got_pc[2], 32'h0);

        // Asynchronous reset mid-stream.
        repeat (3) step(1'b0, 1'b0, 32'h0);
        nrst = 1'b0;
        fq.stall = 1'b0;
        fq.kill = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        got_pc.delete();
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        run_until("rerun", 2, 12);
        if (got_pc.size() >= 2) begin
            check("rerun_pc0", got_pc[0], 32'h0);
            check("rerun_pc1", got_pc[1], 32'h4);
        end

        // Random stall/kill traffic.
        repeat (400) begin
            step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 6, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
